vec_mem: RTL and testbench

Parametrised multi-lane, simple-dual-port operand memory for the dot-product datapath. It has one write port with per-lane write mask and a single-beat read port with 1-cycle latency. A burst read engine streams a contiguous, wrapping address range to the MAC over a valid/ready interface. Configurable read-during-write behaviour.

---
 rtl/vec_mem.sv | 150 +++++++++++++++
 tb/tb_vec_mem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_mem.sv
// Multi-lane simple-dual-port operand memory with a registered single-beat read port
// and a wrapping burst read engine that streams words to the MAC over valid/ready.
module vec_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RDW_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          write_en,
    input  logic [ADDR_WIDTH-1:0]         write_address,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    input  logic [LANES-1:0]              write_mask,
    input  logic                          read_en,
    input  logic [ADDR_WIDTH-1:0]         read_address,
    output logic [LANES*DATA_WIDTH-1:0]   data_out,
    output logic                          data_valid,
    input  logic                          burst_start,
    input  logic [ADDR_WIDTH-1:0]         burst_base,
    input  logic [ADDR_WIDTH:0]           burst_len,
    output logic                          burst_busy,
    output logic                          burst_done,
    output logic [LANES*DATA_WIDTH-1:0]   stream_data,
    output logic                          stream_valid,
    input  logic                          stream_ready,
    output logic                          stream_last
);

    localparam int W = LANES * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [W-1:0]          mem [DEPTH];
    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [ADDR_WIDTH:0]   rem, len_clamped;
    logic                  do_start, do_single, do_fetch, do_finish;
    logic [W-1:0]          single_word, burst_word;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    // Applies the same-edge write to the word being read when new-data forwarding is selected.
    function automatic logic [W-1:0] rdw_view(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [W-1:0]          stored);
        logic [W-1:0] w;
        w = stored;
        if (RDW_MODE == 1 && write_en && write_address == a && in_range(a)) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) w[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return w;
    endfunction

    // NOTE: the storage array has no reset on purpose; contents must survive rst_n and a
    // reset-free array maps onto plain RAM rather than a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (write_en && in_range(write_address)) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i]) begin
                    mem[write_address][i*DATA_WIDTH +: DATA_WIDTH] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        single_word = in_range(read_address) ? rdw_view(read_address, mem[read_address]) : '0;
        burst_word  = in_range(addr) ? rdw_view(addr, mem[addr]) : '0;
        addr_next   = (addr == LAST_A) ? '0 : addr + 1'b1;
        len_clamped = (burst_len > DEPTH_L) ? DEPTH_L : burst_len;
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_single  = 1'b0;
        do_fetch   = 1'b0;
        do_finish  = 1'b0;
        case (state)
            IDLE: begin
                if (burst_start) begin
                    do_start   = 1'b1;
                    state_next = BUSY;
                end else if (read_en) begin
                    do_single = 1'b1;
                end
            end
            BUSY: begin
                if (!stream_valid || stream_ready) begin
                    if (rem != '0) begin
                        do_fetch = 1'b1;
                    end else begin
                        do_finish  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign burst_busy = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
            burst_done   <= 1'b0;
            addr         <= '0;
            rem          <= '0;
        end else begin
            data_valid <= do_single;
            burst_done <= do_finish;
            if (do_single) data_out <= single_word;
            if (do_start) begin
                addr <= burst_base;
                rem  <= len_clamped;
            end
            if (do_fetch) begin
                stream_data  <= burst_word;
                stream_valid <= 1'b1;
                stream_last  <= (rem == (ADDR_WIDTH + 1)'(1));
                addr         <= addr_next;
                rem          <= rem - 1'b1;
            end
            if (do_finish) begin
                stream_valid <= 1'b0;
                stream_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_mem.sv
// Bench for vec_mem: two instances (old-data and new-data read-during-write) share stimulus
// and are compared against a word-array reference model and per-burst expected-beat queues.
module tb_vec_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        write_en = 1'b0, read_en = 1'b0, burst_start = 1'b0, stream_ready = 1'b0;
    logic [3:0]  write_address = '0, read_address = '0, burst_base = '0, write_mask = '0;
    logic [31:0] data_in = '0;
    logic [4:0]  burst_len = '0;

    logic [31:0] dout0, dout1, sd0, sd1;
    logic        dv0, dv1, busy0, busy1, done0, done1, sv0, sv1, sl0, sl1;

    logic [31:0] ref_mem [16];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_mem #(.RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .write_mask(write_mask), .read_en(read_en), .read_address(read_address),
        .data_out(dout0), .data_valid(dv0), .burst_start(burst_start), .burst_base(burst_base),
        .burst_len(burst_len), .burst_busy(busy0), .burst_done(done0), .stream_data(sd0),
        .stream_valid(sv0), .stream_ready(stream_ready), .stream_last(sl0));

    vec_mem #(.RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
        .data_in(data_in), .write_mask(write_mask), .read_en(read_en), .read_address(read_address),
        .data_out(dout1), .data_valid(dv1), .burst_start(burst_start), .burst_base(burst_base),
        .burst_len(burst_len), .burst_busy(busy1), .burst_done(done1), .stream_data(sd1),
        .stream_valid(sv1), .stream_ready(stream_ready), .stream_last(sl1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        write_en = 1'b1; write_address = a; data_in = d; write_mask = m;
        tick();
        write_en = 1'b0;
        ref_mem[a] = merge(ref_mem[a], d, m);
    endtask

    task automatic do_read(input logic [3:0] a);
        read_en = 1'b1; read_address = a;
        tick();
        read_en = 1'b0;
        check("rd_valid0", dv0, 1'b1);
        check("rd_valid1", dv1, 1'b1);
        check("rd_data0", dout0, ref_mem[a]);
        check("rd_data1", dout1, ref_mem[a]);
        tick();
        check("rd_pulse", {dv0, dv1}, 2'b00);
        check("rd_hold", dout0, ref_mem[a]);
    endtask

    // Simultaneous write and read; dut0 must see the old word, dut1 the merged one on a hit.
    task automatic do_rdw(input logic [3:0] wa, input logic [3:0] ra,
                          input logic [31:0] d, input logic [3:0] m);
        logic [31:0] old_r, new_r;
        old_r = ref_mem[ra];
        new_r = (wa == ra) ? merge(ref_mem[ra], d, m) : ref_mem[ra];
        write_en = 1'b1; write_address = wa; data_in = d; write_mask = m;
        read_en = 1'b1; read_address = ra;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        ref_mem[wa] = merge(ref_mem[wa], d, m);
        check("rdw_valid", {dv0, dv1}, 2'b11);
        check("rdw_old", dout0, old_r);
        check("rdw_new", dout1, new_r);
    endtask

    // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random.
    task automatic run_burst(input logic [3:0] base, input logic [4:0] len, input int mode,
                             input bit noisy, input int exp_cycles);
        logic [31:0] q[$];
        logic [31:0] exp_w, prev_data;
        int n, cycles;
        bit done, prev_stall;
        n = (len > 16) ? 16 : int'(len);
        for (int k = 0; k < n; k++) q.push_back(ref_mem[(int'(base) + k) % 16]);
        burst_start = 1'b1; burst_base = base; burst_len = len;
        tick();
        burst_start = 1'b0;
        cycles = 1;
        check("start_busy", {busy0, busy1}, 2'b11);
        check("start_no_valid", {sv0, sv1}, 2'b00);
        done = 0;
        prev_stall = 0;
        prev_data = '0;
        while (!done && cycles < 200) begin
            case (mode)
                0:       stream_ready = 1'b1;
                1:       stream_ready = (cycles % 3 == 1);
                default: stream_ready = 1'($urandom_range(0, 1));
            endcase
            read_en      = noisy;
            read_address = 4'($urandom_range(0, 15));
            burst_start  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (prev_stall) begin
                check("stall_valid", sv0, 1'b1);
                check("stall_data", sd0, prev_data);
            end
            if (sv0 && stream_ready) begin
                check("beat_avail", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check("beat_data0", sd0, exp_w);
                    check("beat_data1", sd1, exp_w);
                    check("beat_last", {sl0, sl1}, {2{q.size() == 0}});
                end
            end
            prev_stall = sv0 && !stream_ready;
            prev_data  = sd0;
            tick();
            cycles++;
            check("no_dv_in_burst", {dv0, dv1}, 2'b00);
            if (done0) done = 1;
        end
        read_en = 1'b0; burst_start = 1'b0; stream_ready = 1'b0;
        check("burst_finished", done, 1'b1);
        check("beats_left", q.size(), 0);
        check("done_both", {done0, done1}, 2'b11);
        check("end_idle", {busy0, busy1, sv0, sl0}, 4'b0000);
        if (exp_cycles > 0) check("burst_cycles", cycles, exp_cycles);
        tick();
        check("done_pulse", {done0, done1}, 2'b00);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_out0", {dout0, dv0, sd0, sv0, sl0, busy0, done0}, '0);
        check("rst_out1", {dout1, dv1, sd1, sv1, sl1, busy1, done1}, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) do_write(4'(i), 32'h0, 4'hF);
        do_write(4'd0, 32'h1122_3344, 4'hF);
        do_write(4'd1, 32'hA5A5_A5A5, 4'hF);
        do_read(4'd0);
        do_read(4'd1);
        do_write(4'd1, 32'hFFFF_FFFF, 4'b0101);
        do_read(4'd1);
        check("masked_value", ref_mem[1], 32'hA5FF_A5FF);
        do_rdw(4'd2, 4'd2, 32'hDEAD_BEEF, 4'hF);
        check("rdw_new_value", dout1, 32'hDEAD_BEEF);

        for (int it = 0; it < 80; it++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 15));
            ra = $urandom_range(0, 1) ? wa : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       do_write(wa, $urandom, 4'($urandom_range(0, 15)));
                1:       do_read(ra);
                default: do_rdw(wa, ra, $urandom, 4'($urandom_range(0, 15)));
            endcase
        end

        for (int i = 0; i < 16; i++) do_write(4'(i), 32'(i), 4'hF);
        run_burst(4'd14, 5'd4, 0, 0, 6);
        run_burst(4'd14, 5'd4, 1, 1, 0);
        run_burst(4'd3, 5'd20, 0, 0, 18);
        run_burst(4'd9, 5'd0, 0, 0, 2);

        for (int it = 0; it < 6; it++) begin
            do_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            run_burst(4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)), 2, 1, 0);
        end

        burst_start = 1'b1; burst_base = 4'd0; burst_len = 5'd10; stream_ready = 1'b1;
        tick();
        burst_start = 1'b0;
        tick(); tick();
        check("pre_abort_valid", sv0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out0", {dout0, dv0, sd0, sv0, sl0, busy0, done0}, '0);
        check("abort_out1", {dout1, dv1, sd1, sv1, sl1, busy1, done1}, '0);
        tick(); tick();
        check("abort_no_done", {done0, done1, busy0, busy1}, 4'b0000);
        rst_n = 1'b1;
        stream_ready = 1'b0;
        tick();
        do_read(4'd5);
        do_read(4'd15);
        run_burst(4'd7, 5'd0, 0, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
